switch_debounce: RTL and testbench
==================================

# switch_debounce

Synchronizes and debounces a vector of raw slide-switch/push-button inputs and presents a clean, glitch-free vector suitable for driving the 8-to-3 priority encoder input `in`. It sits directly upstream of the encoder, between the board I/O pins and the combinational encode stage. A one-cycle change strobe lets downstream logic react only when the debounced vector actually changes. An optional per-bit rising-edge vector is also provided.

## Interface
Parameters:
- `WIDTH`, 8: number of input bits.
- `CNT_W`, 16: width of each per-bit stability counter.
- `STABLE_CYC`, 50000: consecutive cycles a new level must persist before acceptance. Legal range is 2 ≤ `STABLE_CYC` ≤ 2^`CNT_W`.

Ports:
- `clk`, in, 1: single clock. All state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: debounce enable.
- `raw`, in, `WIDTH`: asynchronous raw pin levels.
- `in_db`, out, `WIDTH`: debounced vector. Feeds the encoder `in`.
- `chg`, out, 1: one-cycle pulse when any bit of `in_db` changes.
- `rise`, out, `WIDTH`: one-cycle per-bit 0→1 pulses. Present only with `SWITCH_DEBOUNCE_RISE_EN`.

## Operation
- Each bit has its own independent datapath:
  - A two-flop synchronizer, `s1` then `s2`.
  - An accepted level `q`.
  - A counter `cnt`.
- `in_db[i] = q[i]`. All outputs are registered.
- Per-bit rules, evaluated each cycle while `en=1`:
  - `s2 == q`: `cnt <= 0`. Any bounce back to the accepted level restarts qualification.
  - `s2 != q` and `cnt != STABLE_CYC-1`: `cnt <= cnt+1`.
  - `s2 != q` and `cnt == STABLE_CYC-1`: `q <= s2` and `cnt <= 0`.
- The counter never wraps. It is cleared at `STABLE_CYC-1` at the latest.
- `chg` is registered and is high in exactly the cycle in which `in_db` first shows a new value. If several bits update in the same cycle, `chg` pulses once.
- `rise[i]` is registered and is high in exactly the cycle in which `in_db[i]` first shows a 0→1 transition. A 1→0 transition produces no `rise` pulse.
- When `en=0`:
  - The synchronizers keep sampling.
  - `cnt` is forced to 0 and `q` holds its value.
  - `chg` and `rise` are 0.
- When `en` returns to 1, qualification restarts from zero.
- Reset (`rst=1` at a rising edge):
  - `s1`, `s2`, `q`, `cnt` all become 0.
  - `in_db=0`, `chg=0`, `rise=0`.
  - Reset takes priority over `en` and over any in-progress qualification. Partial counts are discarded.

## Timing
- Clean step on `raw[i]` (first sampled at edge k, held stable, `en=1`):
  - `in_db[i]` takes the new value after edge k+1+`STABLE_CYC`.
  - Total latency is `STABLE_CYC`+2 edges, counting edge k.
- Bounce: a return of `s2` to `q` at any edge before acceptance resets the count. Accepting the new level then requires a fresh `STABLE_CYC` consecutive mismatching cycles.
- A pulse shorter than `STABLE_CYC` cycles at `s2` never reaches `in_db`.
- Bits qualify independently. Simultaneous raw changes on several bits update together only if their `s2` histories are identical.
- Back-to-back acceptances on the same bit are separated by at least `STABLE_CYC` cycles.

## Configuration
- Macro: `SWITCH_DEBOUNCE_RISE_EN`.
- Defined: the `rise` port and its registers exist, with behaviour as above.
- Undefined: the `rise` port and its logic are absent. `in_db` and `chg` are unchanged and cycle-identical.

## Structure
- Package `switch_debounce_pkg`:
  - Default constants `DB_WIDTH=8`, `DB_CNT_W=16`, `DB_STABLE_CYC=50000`.
  - A `localparam`-style helper stating the bench value `DB_STABLE_CYC_SIM=4`.
- Sub-module `debounce_bit`:
  - Single-bit synchronizer, counter and accepted level.
  - Ports: `clk`, `rst`, `en`, `d`, `q`, `upd`.
  - Instantiated `WIDTH` times with a generate loop.
- The top level ORs the `upd` signals into `chg` and forms `rise` from `upd & q`.

## Test plan
All scenarios use `STABLE_CYC=4`.
- Reset check: hold `rst=1` for 2 cycles with `raw=8'hFF` → `in_db=0`, `chg=0`, `rise=0`. After release, `in_db=8'hFF` arrives 6 edges later, with one `chg` pulse and `rise=8'hFF` for one cycle.
- Clean step: `raw` changes 8'h00→8'h10 at edge k → `in_db=8'h10` after edge k+5. `chg` is high only that cycle and `rise=8'h10`.
- Bounce rejection:
  - `raw[3]` toggles 1,0,1,0 per cycle for 10 cycles, then settles at 0 → `in_db[3]` stays 0 throughout.
  - Settling at 1 instead → `in_db[3]` becomes 1 exactly 6 edges after the last toggle.
- Enable gating:
  - With `en=0`, `raw` changes 8'h00→8'h80 and holds for 20 cycles → `in_db` stays 8'h00.
  - Raise `en` → `in_db=8'h80` after `STABLE_CYC` further edges.
- Mid-qualification reset: `raw=8'h01` held for 3 cycles, then `rst=1` for one edge → `in_db=0` and the count restarts. Acceptance occurs 6 edges after reset release.
- Multi-bit and fall:
  - 8'h81→8'h00 → one `chg` pulse, `rise=0`.
  - Combined with the encoder, `y` goes 1→0.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
// Shared constants and the per-bit qualification decision type for switch_debounce.
// The bench uses DB_STABLE_CYC_SIM so that qualification takes a handful of cycles.
package switch_debounce_pkg;

  localparam int DB_WIDTH          = 8;
  localparam int DB_CNT_W          = 16;
  localparam int DB_STABLE_CYC     = 50000;
  localparam int DB_STABLE_CYC_SIM = 4;

  // What a single bit does at the next edge.
  typedef enum logic [1:0] {
    DB_IDLE   = 2'd0,
    DB_MATCH  = 2'd1,
    DB_COUNT  = 2'd2,
    DB_ACCEPT = 2'd3
  } db_act_e;

  // Terminal count value: the counter never goes past STABLE_CYC-1.
  function automatic int db_cnt_last(input int stable_cyc);
    return stable_cyc - 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced bit: two-flop synchronizer, stability counter and accepted level.
// upd is a registered strobe that is high in the cycle q first shows a new level.
module debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int CNT_W      = DB_CNT_W,
  parameter int STABLE_CYC = DB_STABLE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q,
  output logic upd
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(db_cnt_last(STABLE_CYC));

  logic             s1_r;
  logic             s2_r;
  logic             q_r;
  logic             upd_r;
  logic [CNT_W-1:0] cnt_r;

  db_act_e          act_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             q_nxt_s;
  logic             upd_nxt_s;

  // Synchronizer keeps sampling regardless of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  // Classify this cycle; a bounce back to q restarts qualification.
  always_comb begin
    act_s = DB_IDLE;
    if (!en) begin
      act_s = DB_IDLE;
    end else if (s2_r == q_r) begin
      act_s = DB_MATCH;
    end else if (cnt_r == CNT_LAST) begin
      act_s = DB_ACCEPT;
    end else begin
      act_s = DB_COUNT;
    end
  end

  // Next counter, level and strobe values from the classification.
  always_comb begin
    cnt_nxt_s = cnt_r;
    q_nxt_s   = q_r;
    upd_nxt_s = 1'b0;
    case (act_s)
      DB_COUNT: begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
      DB_ACCEPT: begin
        cnt_nxt_s = '0;
        q_nxt_s   = s2_r;
        upd_nxt_s = 1'b1;
      end
      DB_MATCH: begin
        cnt_nxt_s = '0;
      end
      DB_IDLE: begin
        cnt_nxt_s = '0;
      end
      default: begin
        cnt_nxt_s = '0;
      end
    endcase
  end

  // Qualification state; reset discards any partial count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      q_r   <= 1'b0;
      upd_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      q_r   <= q_nxt_s;
      upd_r <= upd_nxt_s;
    end
  end

  assign q   = q_r;
  assign upd = upd_r;

endmodule

// File: rtl/switch_debounce.sv
// Debounces a raw switch vector for the priority encoder; chg strobes on any change.
// Optional rise vector is built only when SWITCH_DEBOUNCE_RISE_EN is defined.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH      = DB_WIDTH,
  parameter int CNT_W      = DB_CNT_W,
  parameter int STABLE_CYC = DB_STABLE_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] in_db,
  output logic             chg
`ifdef SWITCH_DEBOUNCE_RISE_EN
  ,
  output logic [WIDTH-1:0] rise
`endif
);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] upd_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .CNT_W      (CNT_W),
      .STABLE_CYC (STABLE_CYC)
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (raw[i]),
      .q   (q_s[i]),
      .upd (upd_s[i])
    );
  end

  // Both terms are flop outputs, so chg and rise stay glitch-free and aligned with in_db.
  assign in_db = q_s;
  assign chg   = |upd_s;

`ifdef SWITCH_DEBOUNCE_RISE_EN
  assign rise = upd_s & q_s;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Randomized + directed bench for switch_debounce against a window-based reference model.
module tb_switch_debounce;
  import switch_debounce_pkg::*;

  localparam int W = 8;
  localparam int S = DB_STABLE_CYC_SIM;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] raw;
  logic [W-1:0] in_db;
  logic         chg;
`ifdef SWITCH_DEBOUNCE_RISE_EN
  logic [W-1:0] rise;
`endif

  int errors = 0;
  int checks = 0;

  switch_debounce #(
    .WIDTH      (W),
    .CNT_W      (16),
    .STABLE_CYC (S)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .raw   (raw),
    .in_db (in_db),
    .chg   (chg)
`ifdef SWITCH_DEBOUNCE_RISE_EN
    ,
    .rise  (rise)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level is accepted once the synchronized input has
  // disagreed with it for the last S enabled cycles, with no reset in between.
  typedef struct {
    logic [W-1:0] s2;
    bit           en;
  } samp_t;

  samp_t        hist[$];
  logic [W-1:0] m_s1 = '0;
  logic [W-1:0] m_s2 = '0;
  logic [W-1:0] m_q  = '0;
  logic         m_chg = 1'b0;
  logic [W-1:0] m_rise = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [W-1:0] r, input bit e, input bit rs);
    samp_t        smp;
    logic [W-1:0] acc;
    if (rs) begin
      m_s1 = '0; m_s2 = '0; m_q = '0;
      m_chg = 1'b0; m_rise = '0;
      hist.delete();
    end else begin
      smp.s2 = m_s2;
      smp.en = e;
      hist.push_back(smp);
      if (hist.size() > S) void'(hist.pop_front());
      m_s2 = m_s1;
      m_s1 = r;
      acc = '0;
      if (hist.size() == S) begin
        for (int i = 0; i < W; i++) begin
          bit all_diff = 1'b1;
          for (int j = 0; j < S; j++)
            if (!hist[j].en || hist[j].s2[i] == m_q[i]) all_diff = 1'b0;
          acc[i] = all_diff;
        end
      end
      m_q    = m_q ^ acc;
      m_chg  = |acc;
      m_rise = acc & m_q;
    end
  endtask

  task automatic step(input logic [W-1:0] r, input bit e, input bit rs);
    raw = r; en = e; rst = rs;
    @(posedge clk);
    model_edge(r, e, rs);
    #1;
    check_val("in_db", {24'd0, in_db}, {24'd0, m_q});
    check_val("chg", {31'd0, chg}, {31'd0, m_chg});
`ifdef SWITCH_DEBOUNCE_RISE_EN
    check_val("rise", {24'd0, rise}, {24'd0, m_rise});
`endif
  endtask

  task automatic settle(input logic [W-1:0] r, input int n);
    for (int i = 0; i < n; i++) step(r, 1'b1, 1'b0);
  endtask

  logic [W-1:0] cur;
  bit           e_r;
  bit           rs_r;

  initial begin
    raw = '0; en = 1'b1; rst = 1'b1;

    // Reset with all switches high, then release
    step(8'hFF, 1'b1, 1'b1);
    step(8'hFF, 1'b1, 1'b1);
    check_val("rst_in_db", {24'd0, in_db}, 32'h0);
    check_val("rst_chg", {31'd0, chg}, 32'h0);
    for (int i = 0; i < 5; i++) step(8'hFF, 1'b1, 1'b0);
    check_val("rel_early", {24'd0, in_db}, 32'h0);
    step(8'hFF, 1'b1, 1'b0);
    check_val("rel_in_db", {24'd0, in_db}, 32'hFF);
    check_val("rel_chg", {31'd0, chg}, 32'h1);
`ifdef SWITCH_DEBOUNCE_RISE_EN
    check_val("rel_rise", {24'd0, rise}, 32'hFF);
`endif
    step(8'hFF, 1'b1, 1'b0);
    check_val("rel_chg_once", {31'd0, chg}, 32'h0);

    // Clean step 00 -> 10
    settle(8'h00, 10);
    for (int i = 0; i < 5; i++) step(8'h10, 1'b1, 1'b0);
    check_val("step_early", {24'd0, in_db}, 32'h0);
    step(8'h10, 1'b1, 1'b0);
    check_val("step_in_db", {24'd0, in_db}, 32'h10);
    check_val("step_chg", {31'd0, chg}, 32'h1);
`ifdef SWITCH_DEBOUNCE_RISE_EN
    check_val("step_rise", {24'd0, rise}, 32'h10);
`endif
    step(8'h10, 1'b1, 1'b0);
    check_val("step_chg_off", {31'd0, chg}, 32'h0);

    // Bounce on bit 3 settling at 0, then settling at 1
    settle(8'h00, 10);
    for (int c = 0; c < 10; c++) step((c % 2 == 0) ? 8'h08 : 8'h00, 1'b1, 1'b0);
    settle(8'h00, 8);
    check_val("bounce0", {24'd0, in_db}, 32'h0);
    for (int c = 0; c < 10; c++) step((c % 2 == 0) ? 8'h08 : 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(8'h08, 1'b1, 1'b0);
    check_val("bounce1_early", {24'd0, in_db}, 32'h0);
    step(8'h08, 1'b1, 1'b0);
    check_val("bounce1", {24'd0, in_db}, 32'h08);

    // Enable gating
    settle(8'h00, 10);
    for (int i = 0; i < 20; i++) step(8'h80, 1'b0, 1'b0);
    check_val("en_off", {24'd0, in_db}, 32'h0);
    for (int i = 0; i < 3; i++) step(8'h80, 1'b1, 1'b0);
    check_val("en_early", {24'd0, in_db}, 32'h0);
    step(8'h80, 1'b1, 1'b0);
    check_val("en_on", {24'd0, in_db}, 32'h80);

    // Reset in the middle of qualification
    settle(8'h00, 10);
    for (int i = 0; i < 3; i++) step(8'h01, 1'b1, 1'b0);
    step(8'h01, 1'b1, 1'b1);
    check_val("midrst", {24'd0, in_db}, 32'h0);
    for (int i = 0; i < 5; i++) step(8'h01, 1'b1, 1'b0);
    check_val("midrst_early", {24'd0, in_db}, 32'h0);
    step(8'h01, 1'b1, 1'b0);
    check_val("midrst_acc", {24'd0, in_db}, 32'h01);

    // Multi-bit fall 81 -> 00
    settle(8'h81, 10);
    check_val("fall_pre", {24'd0, in_db}, 32'h81);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    check_val("fall_in_db", {24'd0, in_db}, 32'h0);
    check_val("fall_chg", {31'd0, chg}, 32'h1);
`ifdef SWITCH_DEBOUNCE_RISE_EN
    check_val("fall_rise", {24'd0, rise}, 32'h0);
`endif

    // Random bouncing, enable drops and occasional resets
    cur = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) cur = cur ^ W'($urandom);
      e_r  = ($urandom_range(0, 19) != 0);
      rs_r = ($urandom_range(0, 299) == 0);
      step(cur, e_r, rs_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
